if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the pipelined RV32I core; the requesting end of the instruction-memory interface.
- Owns the program counter and drives the word address to instruction memory each cycle.
- Accepts returned instruction words and fills the IF/ID pipeline register.
- Handles stall, branch/jump redirect (flush), boot sequencing, and slow-memory bubbles.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, encoding inserted on bubble/flush (ADDI x0,x0,0).

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  XLEN  byte address to instruction memory, always 4-aligned; equals pc_q.
- imem_req  output  1  fetch request valid.
- imem_rdata  input  32  instruction word for imem_addr.
- imem_ready  input  1  imem_rdata valid this cycle; tie to 1 for a combinational memory.
- stall_i  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect_i  input  1  taken branch/jump from EX; flush and reload PC.
- redirect_pc_i  input  XLEN  target address; bits[1:0] ignored, forced to 0.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc  output  XLEN  registered PC of if_id_instr.
- if_id_valid  output  1  if_id_instr is a real fetched instruction.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - pc_q=RESET_PC, state=BOOT.
  - if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_valid=0.
  - imem_req is combinationally 0 in BOOT.
- Reset overrides every other input, including mid-stall and mid-redirect.
- FSM states: BOOT, RUN, FLUSH.
- BOOT:
  - imem_req=0; lasts exactly one cycle after rst deasserts.
  - Next state is RUN; PC and IF/ID unchanged.
- RUN:
  - imem_req=1, imem_addr=pc_q.
  - Priority per cycle: redirect_i > stall_i > imem_ready.
  - redirect_i=1: pc_q<=redirect_pc_i & ~3; IF/ID<=NOP_INSTR, valid=0; if_id_pc<=redirect target; next=FLUSH. Applies even when stall_i=1.
  - stall_i=1 (no redirect): pc_q, if_id_instr, if_id_pc, if_id_valid all held; imem_req stays 1; response is discarded.
  - imem_ready=1: if_id_instr<=imem_rdata, if_id_pc<=pc_q, if_id_valid<=1, pc_q<=pc_q+4.
  - imem_ready=0: pc_q held; IF/ID<=NOP_INSTR, valid=0 (bubble).
- FLUSH:
  - imem_req=0 for one cycle, giving a 2-cycle redirect penalty; IF/ID keeps the NOP.
  - A redirect_i arriving in FLUSH reloads pc_q again and remains in FLUSH.
  - Otherwise next=RUN.
- Latency: combinational memory gives one instruction per cycle; address in cycle N appears on if_id_* after the posedge ending cycle N.
- PC arithmetic: modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0 with no flag.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0]; both reset to 0.
  - fetch_cnt increments on every IF/ID load with valid=1.
  - bubble_cnt increments every cycle where state≠BOOT and IF/ID is not loaded with a valid instruction (stall, imem_ready=0, redirect, FLUSH).
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run with imem_ready=1, memory word k = 32'h00100093+k:
  - Cycle 1 after reset: imem_req=0.
  - Then if_id_pc=0,4,8,… with matching instr and valid=1 every cycle.
- stall_i=1 for 3 cycles while pc_q=8:
  - imem_addr stays 8; if_id_* frozen at pc=4.
  - After release, next IF/ID is pc=8.
- redirect_i with redirect_pc_i=32'h00000043 while stall_i=1:
  - Next cycle: valid=0, instr=32'h00000013, state FLUSH.
  - Then fetch from 32'h40; first valid if_id_pc=32'h40 two cycles after the redirect.
- imem_ready=0 for 2 cycles at pc=12: two bubbles (valid=0, NOP); pc_q stays 12; then 12 is delivered.
- rst asserted mid-FLUSH: next cycle pc_q=RESET_PC, valid=0, state BOOT.
- pc_q=32'hFFFFFFFC with ready=1: next pc_q=0. With IF_PERF_CNT_EN, after 10 valid fetches and 3 stall cycles: fetch_cnt=10, bubble_cnt=3.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives instruction memory and fills IF/ID.
// Optional perf counters are compiled in when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_p1, instr_d;
    logic [XLEN-1:0] pc_p1, pc_p1_d;
    logic            vld_p1, vld_d;
    logic            load_valid;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc_i & ~XLEN'(3);
    assign imem_addr       = pc_q;
    assign if_id_instr     = instr_p1;
    assign if_id_pc        = pc_p1;
    assign if_id_valid     = vld_p1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_p1;
        pc_p1_d    = pc_p1;
        vld_d      = vld_p1;
        imem_req   = 1'b0;
        load_valid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    instr_d = NOP_INSTR;
                    pc_p1_d = redirect_target;
                    vld_d   = 1'b0;
                    state_d = FLUSH;
                end else if (stall_i) begin
                    // Response is dropped; the same address is re-requested next cycle.
                    pc_d = pc_q;
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    pc_p1_d    = pc_q;
                    vld_d      = 1'b1;
                    pc_d       = pc_q + XLEN'(4);
                    load_valid = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                end
            end
            FLUSH: begin
                // A second redirect while flushing simply retargets and keeps flushing.
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    pc_p1_d = redirect_target;
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Fetch stage (pc_q) -> IF/ID stage (_p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_p1 <= NOP_INSTR;
            pc_p1    <= RESET_PC;
            vld_p1   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_p1 <= instr_d;
            pc_p1    <= pc_p1_d;
            vld_p1   <= vld_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFFFFFF) ? cnt : cnt + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (load_valid)
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (state_q != BOOT && !load_valid)
                perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
        end
    end
`endif

endmodule
